// File: rtl/h264quantise_param.sv
// h264quantise_param: pipelined H.264 4x4 coefficient quantiser with per-block nonzero count
module h264quantise_param #(
  parameter int IW = 16,
  parameter int OW = 12
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ENABLE,
  input  logic          DCCI,
  input  logic          INTRA,
  input  logic [5:0]    QP,
  input  logic [IW-1:0] YNIN,
  output logic          VALID,
  output logic          DCCO,
  output logic          ZLAST,
  output logic [OW-1:0] ZOUT,
  output logic [4:0]    NNZ,
  output logic          NNZ_VALID
);
  localparam int PW = IW + 14;
  localparam int SW = IW + 15;
  localparam logic [OW-1:0] MAXV = {1'b0, {(OW-1){1'b1}}};
  // per-coefficient control bits carried down the pipe: {valid, dc, last, first, negative}
  logic [4:0]    r_ctl [1:4];
  logic [3:0]    r_zig;
  logic [5:0]    r_qp;
  logic          r_intra;
  logic [IW-1:0] r_mag;
  logic [13:0]   r_qmf;
  logic [5:0]    r_sh1, r_sh2, r_sh3;
  logic [19:0]   r_f1, r_f2;
  logic [PW-1:0] r_p;
  logic [SW-1:0] r_sum, r_m;
  logic [4:0]    r_cnt;
  logic          w_ld, w_intra, w_neg;
  logic [1:0]    w_cls;
  logic [5:0]    w_qp, w_div, w_mod, w_sh;
  logic [13:0]   w_qmf;
  logic [19:0]   w_f;
  logic [IW-1:0] w_mag;
  logic [4:0]    w_ctl, w_c, w_cnt;
  logic [OW-1:0] w_cl, w_z;
  // multiplier table: class 0 = A, 1 = B, 2 = C, indexed by QP mod 6
  function automatic logic [13:0] qmf(input logic [5:0] m, input logic [1:0] c);
    case (m)
      6'd0:    qmf = c == 2'd0 ? 14'd13107 : c == 2'd1 ? 14'd5243 : 14'd8066;
      6'd1:    qmf = c == 2'd0 ? 14'd11916 : c == 2'd1 ? 14'd4660 : 14'd7490;
      6'd2:    qmf = c == 2'd0 ? 14'd10082 : c == 2'd1 ? 14'd4194 : 14'd6554;
      6'd3:    qmf = c == 2'd0 ? 14'd9362  : c == 2'd1 ? 14'd3647 : 14'd5825;
      6'd4:    qmf = c == 2'd0 ? 14'd8192  : c == 2'd1 ? 14'd3355 : 14'd5243;
      default: qmf = c == 2'd0 ? 14'd7282  : c == 2'd1 ? 14'd2893 : 14'd4559;
    endcase
  endfunction
  // block parameters are taken live on the first coefficient of a block, then held
  always_comb begin
    w_ld    = ENABLE & (r_zig == 4'd15 | DCCI);
    w_qp    = w_ld ? QP : r_qp;
    w_intra = w_ld ? INTRA : r_intra;
    w_div   = w_qp / 6'd6;
    w_mod   = w_qp % 6'd6;
    w_sh    = 6'd13 + w_div;
    w_cls   = (r_zig == 4'd0 || r_zig == 4'd3 || r_zig == 4'd5 || r_zig == 4'd11) ? 2'd0 :
              (r_zig == 4'd4 || r_zig == 4'd10 || r_zig == 4'd12 || r_zig == 4'd15) ? 2'd1 : 2'd2;
    w_qmf   = DCCI ? qmf(w_mod, 2'd0) >> 1 : qmf(w_mod, w_cls);
    w_f     = w_intra ? 20'd11 << (w_sh - 6'd5) : 20'd11 << (w_sh - 6'd6);
    w_neg   = YNIN[IW-1];
    w_mag   = w_neg ? -YNIN : YNIN;
    w_ctl   = {ENABLE, DCCI, ~DCCI & (r_zig == 4'd0), ~DCCI & (r_zig == 4'd15), w_neg};
  end
  // zigzag position counter and per-block parameter latch
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_zig   <= 4'd15;
      r_qp    <= '0;
      r_intra <= 1'b0;
    end else begin
      r_zig <= (ENABLE & ~DCCI) ? r_zig - 4'd1 : 4'd15;
      if (w_ld) begin
        r_qp    <= QP;
        r_intra <= INTRA;
      end
    end
  end
  // control pipe; clearing it on reset drops every coefficient in flight
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 1; i <= 4; i++) r_ctl[i] <= '0;
    end else begin
      r_ctl[1] <= w_ctl;
      for (int i = 2; i <= 4; i++) r_ctl[i] <= r_ctl[i-1];
    end
  end
  // datapath: operands, exact product, add rounding offset, shift
  always_ff @(posedge CLK) begin
    r_mag <= w_mag;
    r_qmf <= w_qmf;
    r_sh1 <= w_sh;
    r_f1  <= w_f;
    r_p   <= PW'(r_mag) * PW'(r_qmf);
    r_sh2 <= r_sh1;
    r_f2  <= r_f1;
    r_sum <= SW'(r_p) + SW'(r_f2);
    r_sh3 <= r_sh2;
    r_m   <= r_sum >> r_sh3;
  end
  // symmetric clip on the magnitude, then sign restore; count restarts on a block's first coefficient
  always_comb begin
    w_c   = r_ctl[4];
    w_cl  = r_m > SW'(MAXV) ? MAXV : r_m[OW-1:0];
    w_z   = w_c[0] ? -w_cl : w_cl;
    w_cnt = (w_c[1] ? 5'd0 : r_cnt) + {4'd0, |w_cl};
  end
  // output registers and nonzero count
  always_ff @(posedge CLK) begin
    if (RESET) begin
      VALID     <= 1'b0;
      DCCO      <= 1'b0;
      ZLAST     <= 1'b0;
      NNZ_VALID <= 1'b0;
      ZOUT      <= '0;
      NNZ       <= '0;
      r_cnt     <= '0;
    end else begin
      VALID     <= w_c[4];
      DCCO      <= w_c[4] & w_c[3];
      ZLAST     <= w_c[4] & w_c[2];
      NNZ_VALID <= ZLAST;
      if (w_c[4]) ZOUT <= w_z;
      if (w_c[4] & ~w_c[3]) begin
        r_cnt <= w_c[2] ? 5'd0 : w_cnt;
        if (w_c[2]) NNZ <= w_cnt;
      end
    end
  end
endmodule

// File: tb/tb_h264quantise_param.sv
// tb_h264quantise_param: directed vectors and block sequences for h264quantise_param
module tb_h264quantise_param;
  logic        CLK = 1'b0;
  logic        RESET, ENABLE, DCCI, INTRA;
  logic [5:0]  QP;
  logic [15:0] YNIN;
  logic        VALID, DCCO, ZLAST, NNZ_VALID;
  logic [11:0] ZOUT;
  logic [4:0]  NNZ;
  typedef struct {bit dc; bit it; int qp; int y; int z;} vec_t;
  typedef struct {int z; bit dc; bit last;} out_t;
  vec_t vt[15];
  out_t oq[$];
  out_t o;
  int   nq[$];
  int   errs = 0, checks = 0, cyc = 0, zl_cyc = -10;
  int   ys[16], ev[16];
  h264quantise_param dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DCCI(DCCI), .INTRA(INTRA), .QP(QP), .YNIN(YNIN),
    .VALID(VALID), .DCCO(DCCO), .ZLAST(ZLAST), .ZOUT(ZOUT), .NNZ(NNZ), .NNZ_VALID(NNZ_VALID)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask
  always @(negedge CLK) begin
    if (VALID) begin
      oq.push_back('{int'($signed(ZOUT)), DCCO, ZLAST});
      if (ZLAST) zl_cyc = cyc;
    end
    if (NNZ_VALID) begin
      nq.push_back(int'(NNZ));
      chk("nnz_valid_timing", cyc, zl_cyc + 1);
    end
  end
  task automatic step(input bit en, input bit dc, input bit it, input int q, input int y);
    ENABLE = en;
    DCCI   = dc;
    INTRA  = it;
    QP     = 6'(q);
    YNIN   = 16'(y);
    @(posedge CLK);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask
  function automatic int cls(input int p);
    case (p)
      0, 3, 5, 11:   return 1600;
      4, 10, 12, 15: return 640;
      default:       return 984;
    endcase
  endfunction
  task automatic run_block(input int q, input bit it, input int qm, input bit itm, input int yv[16]);
    for (int p = 15; p >= 0; p--) step(1, 0, p <= 10 ? itm : it, p <= 10 ? qm : q, yv[p]);
    idle(8);
  endtask
  task automatic check_block(input string n, input int e[16], input int en);
    out_t b;
    chk({n, "_count"}, oq.size(), 16);
    for (int k = 0; k < 16 && oq.size() > 0; k++) begin
      b = oq.pop_front();
      chk($sformatf("%s_z%0d", n, 15 - k), b.z, e[15 - k]);
      chk($sformatf("%s_last%0d", n, 15 - k), int'(b.last), int'(k == 15));
    end
    chk({n, "_nnz_pulses"}, nq.size(), 1);
    if (nq.size() > 0) chk({n, "_nnz"}, nq[0], en);
    oq.delete();
    nq.delete();
  endtask
  initial begin
    int lat;
    vt[0]  = '{0, 1, 0, 32767, 2047};
    vt[1]  = '{0, 1, 0, -32767, -2047};
    vt[2]  = '{1, 1, 12, 1000, 200};
    vt[3]  = '{0, 1, 0, 100, 64};
    vt[4]  = '{0, 0, 0, 100, 64};
    vt[5]  = '{0, 1, 28, -500, -13};
    vt[6]  = '{0, 0, 28, -500, -12};
    vt[7]  = '{0, 1, 51, 20000, 35};
    vt[8]  = '{0, 1, 0, 1, 0};
    vt[9]  = '{0, 0, 0, 2, 1};
    vt[10] = '{0, 1, 0, -1, 0};
    vt[11] = '{1, 1, 5, -3000, -1333};
    vt[12] = '{0, 1, 0, -32768, -2047};
    vt[13] = '{1, 1, 0, 32767, 2047};
    vt[14] = '{0, 1, 17, 777, 68};
    RESET = 1'b1;
    idle(3);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_zout", int'(ZOUT), 0);
    chk("rst_nnz", int'(NNZ), 0);
    chk("rst_nnz_valid", int'(NNZ_VALID), 0);
    RESET = 1'b0;
    idle(2);
    oq.delete();
    // single coefficients at position 15 or DC
    for (int i = 0; i < 15; i++) begin
      step(1, vt[i].dc, vt[i].it, vt[i].qp, vt[i].y);
      idle(1);
    end
    idle(6);
    chk("vec_count", oq.size(), 15);
    for (int i = 0; i < 15 && oq.size() > 0; i++) begin
      o = oq.pop_front();
      chk($sformatf("vec%0d_z", i), o.z, vt[i].z);
      chk($sformatf("vec%0d_dc", i), int'(o.dc), int'(vt[i].dc));
      chk($sformatf("vec%0d_last", i), int'(o.last), 0);
    end
    chk("hold_valid", int'(VALID), 0);
    chk("hold_zout", int'($signed(ZOUT)), 68);
    chk("dc_nnz_unchanged", int'(NNZ), 0);
    chk("dc_no_nnz_pulse", nq.size(), 0);
    oq.delete();
    // latency from ENABLE sample to VALID
    step(1, 0, 1, 0, 100);
    ENABLE = 1'b0;
    lat = 0;
    while (!VALID && lat < 10) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    chk("latency", lat, 4);
    chk("latency_z", int'($signed(ZOUT)), 64);
    idle(6);
    oq.delete();
    nq.delete();
    // single nonzero at position 0, intra / inter / negative
    for (int p = 0; p < 16; p++) begin ys[p] = 0; ev[p] = 0; end
    ys[0] = 3; ev[0] = 5;
    run_block(0, 1, 0, 1, ys);
    check_block("blk_intra", ev, 1);
    ev[0] = 4;
    run_block(0, 0, 0, 0, ys);
    check_block("blk_inter", ev, 1);
    ys[0] = -3; ev[0] = -5;
    run_block(0, 1, 0, 1, ys);
    check_block("blk_neg", ev, 1);
    // all classes; QP/INTRA changes mid-block must be ignored
    for (int p = 0; p < 16; p++) begin ys[p] = 1000; ev[p] = cls(p); end
    run_block(0, 1, 51, 0, ys);
    check_block("blk_class", ev, 16);
    // partial block aborted after 5, then a full block with 8 nonzeros
    for (int p = 15; p >= 11; p--) step(1, 0, 1, 0, 1000);
    idle(1);
    for (int p = 0; p < 16; p++) begin
      ys[p] = (p % 2 == 0) ? 1000 : 0;
      ev[p] = (p % 2 == 0) ? cls(p) : 0;
    end
    run_block(0, 1, 0, 1, ys);
    chk("abort_count", oq.size(), 21);
    for (int p = 15; p >= 11 && oq.size() > 0; p--) begin
      o = oq.pop_front();
      chk($sformatf("abort_z%0d", p), o.z, cls(p));
      chk($sformatf("abort_last%0d", p), int'(o.last), 0);
    end
    check_block("blk_after_abort", ev, 8);
    // reset pulsed on the 8th coefficient
    for (int p = 15; p >= 9; p--) step(1, 0, 1, 0, 1000);
    RESET = 1'b1;
    step(1, 0, 1, 0, 1000);
    RESET = 1'b0;
    chk("mrst_valid", int'(VALID), 0);
    chk("mrst_zout", int'(ZOUT), 0);
    chk("mrst_nnz", int'(NNZ), 0);
    chk("mrst_dcco", int'(DCCO), 0);
    chk("mrst_zlast", int'(ZLAST), 0);
    chk("mrst_nnz_valid", int'(NNZ_VALID), 0);
    idle(8);
    chk("mrst_count", oq.size(), 3);
    for (int p = 15; p >= 13 && oq.size() > 0; p--) begin
      o = oq.pop_front();
      chk($sformatf("mrst_z%0d", p), o.z, cls(p));
    end
    chk("mrst_no_nnz", nq.size(), 0);
    oq.delete();
    nq.delete();
    for (int p = 0; p < 16; p++) begin ys[p] = 0; ev[p] = 0; end
    ys[0] = 3; ev[0] = 5;
    run_block(0, 1, 0, 1, ys);
    check_block("blk_after_rst", ev, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
